tmp_seq_ctrl: RTL and testbench

Parametrised sequencer for the switched-capacitor temperature sensor front end. It drives the diode, big-diode and charge-transfer switch phases, precharge and comparator clocking, then runs a bias-setup loop. It runs N_CONV incremental delta-sigma iterations and reports the count of comparator-high decisions as `result` with a one-cycle `valid`. Supports single-shot and continuous conversion; sits between the analog core and the readout register block.

---
 rtl/tmp_pkg.sv | 41 ++++
 rtl/tmp_phase_cnt.sv | 24 ++
 rtl/tmp_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_tmp_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmp_pkg.sv
// Shared definitions for the temperature-sensor sequencer and its readout block.
package tmp_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_PRECHARGE, S_SETUP, S_BLANK_BD, S_BIGDIODE, S_BLANK_D,
    S_DIODE, S_BLANK_CH, S_CHARGE_H, S_CHARGE_L, S_OUTPUT
  } tmp_state_t;

  localparam int DEF_PRE_CYC    = 64;
  localparam int DEF_BD_CYC     = 12;
  localparam int DEF_D_CYC      = 9;
  localparam int DEF_CH_CYC     = 6;
  localparam int DEF_N_CONV     = 16;
  localparam int DEF_SETUP_LOWS = 5;
  localparam int DEF_SETUP_MAX  = 63;

  // Switch-phase bundle driven towards the analog core.
  typedef struct packed {
    logic pi1, pi2, pii1, pii2, pa, pb, pc, pd;
  } tmp_sw_t;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Static switch pattern held for the whole of a state.
  function automatic tmp_sw_t sw_for(tmp_state_t s);
    tmp_sw_t sw;
    sw = '0;
    case (s)
      S_IDLE, S_PRECHARGE, S_OUTPUT: begin sw.pb = 1'b1; sw.pc = 1'b1; sw.pd = 1'b1; end
      S_SETUP, S_BIGDIODE:           begin sw.pi1 = 1'b1; sw.pi2 = 1'b1; end
      S_DIODE:                       begin sw.pii1 = 1'b1; sw.pii2 = 1'b1; end
      S_CHARGE_H:                    begin sw.pa = 1'b1; sw.pb = 1'b1; end
      S_CHARGE_L:                    begin sw.pa = 1'b1; sw.pc = 1'b1; end
      default:                       sw = '0;
    endcase
    return sw;
  endfunction

endpackage

// File: rtl/tmp_phase_cnt.sv
// Loadable down-counter with terminal flag; one instance times every phase.
module tmp_phase_cnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // load takes priority; otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (reset)           cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  // a phase loaded with len-1 lasts len cycles and ends on the cycle tc is high
  assign tc = (cnt == '0);

endmodule

// File: rtl/tmp_seq_ctrl.sv
// Switched-capacitor temperature sensor sequencer: precharge, bias setup,
// N_CONV incremental delta-sigma iterations, result strobe.
module tmp_seq_ctrl
  import tmp_pkg::*;
#(
  parameter int PRE_CYC    = DEF_PRE_CYC,
  parameter int BD_CYC     = DEF_BD_CYC,
  parameter int D_CYC      = DEF_D_CYC,
  parameter int CH_CYC     = DEF_CH_CYC,
  parameter int N_CONV     = DEF_N_CONV,
  parameter int SETUP_LOWS = DEF_SETUP_LOWS,
  parameter int SETUP_MAX  = DEF_SETUP_MAX,
  parameter int RES_W      = $clog2(N_CONV + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             cmp,
  output logic             PI1,
  output logic             PI2,
  output logic             PII1,
  output logic             PII2,
  output logic             PA,
  output logic             PB,
  output logic             PC,
  output logic             PD,
  output logic             s_BG2CMP,
  output logic             src_n,
  output logic             snk,
  output logic             cmp_p1,
  output logic             cmp_p2,
  output logic             preChrg,
  output logic             setupBias,
  output logic             busy,
  output logic             setupFail,
  output logic             valid,
  output logic [RES_W-1:0] result
);

  localparam int CNT_MAX = imax(imax(PRE_CYC, SETUP_MAX), imax(imax(BD_CYC, D_CYC), CH_CYC));
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int LW      = $clog2(SETUP_LOWS + 1);

  tmp_state_t       state, nxt;
  tmp_sw_t          sw;
  logic [RES_W-1:0] acc, iter;
  logic [LW-1:0]    lows;
  logic             d, tc, ld, lows_done;
  logic [CW-1:0]    ld_val;

  tmp_phase_cnt #(.W(CW)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .load_val (ld_val),
    .tc       (tc)
  );

  assign {PI1, PI2, PII1, PII2, PA, PB, PC, PD} = sw;

  // next state, and phase-counter reload on every state change
  always_comb begin
    nxt       = state;
    ld_val    = '0;
    lows_done = !cmp && (lows == LW'(SETUP_LOWS - 1));
    case (state)
      S_IDLE:                 if (start) nxt = S_PRECHARGE;
      S_PRECHARGE:            if (tc) nxt = S_SETUP;
      S_SETUP:                if (lows_done || tc) nxt = S_BLANK_BD;
      S_BLANK_BD:             nxt = S_BIGDIODE;
      S_BIGDIODE:             if (tc) nxt = S_BLANK_D;
      S_BLANK_D:              nxt = S_DIODE;
      S_DIODE:                if (tc) nxt = S_BLANK_CH;
      S_BLANK_CH:             nxt = d ? S_CHARGE_H : S_CHARGE_L;
      S_CHARGE_H, S_CHARGE_L: if (tc) nxt = (iter == RES_W'(N_CONV - 1)) ? S_OUTPUT : S_BLANK_BD;
      S_OUTPUT:               nxt = continuous ? S_PRECHARGE : S_IDLE;
      default:                nxt = S_IDLE;
    endcase
    case (nxt)
      S_PRECHARGE:            ld_val = CW'(PRE_CYC - 1);
      S_SETUP:                ld_val = CW'(SETUP_MAX - 1);
      S_BIGDIODE:             ld_val = CW'(BD_CYC - 1);
      S_DIODE:                ld_val = CW'(D_CYC - 1);
      S_CHARGE_H, S_CHARGE_L: ld_val = CW'(CH_CYC - 1);
      default:                ld_val = '0;
    endcase
    ld = (nxt != state);
  end

  // state register and all outputs, registered from the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sw        <= sw_for(S_IDLE);
      cmp_p1    <= 1'b1;
      cmp_p2    <= 1'b0;
      s_BG2CMP  <= 1'b0;
      src_n     <= 1'b1;
      snk       <= 1'b0;
      preChrg   <= 1'b0;
      setupBias <= 1'b0;
      busy      <= 1'b0;
      setupFail <= 1'b0;
      valid     <= 1'b0;
      result    <= '0;
      acc       <= '0;
      iter      <= '0;
      lows      <= '0;
      d         <= 1'b0;
    end else begin
      state     <= nxt;
      sw        <= sw_for(nxt);
      busy      <= (nxt != S_IDLE);
      preChrg   <= (nxt == S_PRECHARGE);
      setupBias <= (nxt == S_PRECHARGE) || (nxt == S_SETUP);
      s_BG2CMP  <= (nxt == S_PRECHARGE) || (nxt == S_SETUP);
      valid     <= (nxt == S_OUTPUT);
      src_n     <= 1'b1;
      snk       <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          setupFail <= 1'b0;
          acc       <= '0;
          iter      <= '0;
        end
        S_PRECHARGE: begin
          lows <= '0;
          if (tc) begin cmp_p1 <= ~cmp_p1; cmp_p2 <= ~cmp_p2; end
        end
        S_SETUP: begin
          // bias nudged up on cmp=1, down on cmp=0; pulse follows the sample
          if (cmp) begin src_n <= 1'b0; lows <= '0; end
          else     begin snk <= 1'b1; lows <= lows + 1'b1; end
          if (tc && !lows_done) setupFail <= 1'b1;
        end
        S_DIODE: if (tc) begin
          d      <= cmp;
          cmp_p1 <= ~cmp_p1;
          cmp_p2 <= ~cmp_p2;
        end
        S_BLANK_CH: if (d) acc <= acc + 1'b1;
        S_CHARGE_H, S_CHARGE_L: if (tc) begin
          iter <= iter + 1'b1;
          if (iter == RES_W'(N_CONV - 1)) result <= acc;
        end
        S_OUTPUT: begin
          if (continuous) begin acc <= '0; iter <= '0; end
          else begin cmp_p1 <= 1'b1; cmp_p2 <= 1'b0; end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tmp_seq_ctrl.sv
// Scoreboard bench for tmp_seq_ctrl: randomized comparator stimulus, spec-level model.
module tb_tmp_seq_ctrl;
  import tmp_pkg::*;

  localparam int PRE   = DEF_PRE_CYC;
  localparam int BD    = DEF_BD_CYC;
  localparam int DC    = DEF_D_CYC;
  localparam int CH    = DEF_CH_CYC;
  localparam int N     = DEF_N_CONV;
  localparam int LOWS  = DEF_SETUP_LOWS;
  localparam int SMAX  = DEF_SETUP_MAX;
  localparam int L     = BD + DC + CH + 3;
  localparam int RES_W = $clog2(N + 1);
  localparam logic [17:0] RST_VEC = 18'b000001110101000000;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, continuous = 1'b0, cmp = 1'b0;
  logic PI1, PI2, PII1, PII2, PA, PB, PC, PD, s_BG2CMP, src_n, snk;
  logic cmp_p1, cmp_p2, preChrg, setupBias, busy, setupFail, valid;
  logic [RES_W-1:0] result;

  tmp_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .cmp(cmp),
    .PI1(PI1), .PI2(PI2), .PII1(PII1), .PII2(PII2),
    .PA(PA), .PB(PB), .PC(PC), .PD(PD),
    .s_BG2CMP(s_BG2CMP), .src_n(src_n), .snk(snk),
    .cmp_p1(cmp_p1), .cmp_p2(cmp_p2), .preChrg(preChrg), .setupBias(setupBias),
    .busy(busy), .setupFail(setupFail), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res; int fail; int vcyc; int src; int snk; int ones;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0, n_errs = 0;
  int cyc = 0;
  int mfail = 0;
  int bi = 0;
  logic [63:0]  cur_setup = '1;
  logic [N-1:0] cur_bits  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [17:0] outvec();
    return {PI1, PI2, PII1, PII2, PA, PB, PC, PD, s_BG2CMP, src_n, snk,
            cmp_p1, cmp_p2, preChrg, setupBias, busy, setupFail, valid};
  endfunction

  // Build one conversion: comparator patterns for driver and the expected outcome.
  // ps = edge on which PRECHARGE is entered.
  task automatic prep(input int sm, input int bm, input int ps, input bit chained, output exp_t e);
    logic [63:0]  s;
    logic [N-1:0] b;
    int lows, scyc, f;
    bit done;
    for (int k = 0; k < 64; k++)
      case (sm)
        0:       s[k] = ($urandom_range(0, 3) == 0);
        1:       s[k] = 1'b0;
        2:       s[k] = 1'b1;
        default: s[k] = (k < 58);
      endcase
    for (int i = 0; i < N; i++)
      case (bm)
        0:       b[i] = 1'($urandom);
        1:       b[i] = 1'b1;
        2:       b[i] = 1'b0;
        default: b[i] = (i % 2 == 0);
      endcase
    lows = 0; scyc = SMAX; f = 1; done = 0;
    e.src = 0; e.snk = 0;
    for (int k = 1; k <= SMAX; k++) begin
      if (!done) begin
        if (s[k-1]) begin lows = 0; e.src++; end
        else        begin lows++;   e.snk++; end
        if (lows == LOWS) begin scyc = k; f = 0; done = 1; end
      end
    end
    if (!chained) mfail = 0;
    mfail = mfail | f;
    e.fail = mfail;
    e.ones = $countones(b);
    e.res  = e.ones;
    e.vcyc = ps + PRE + scyc + N * L;
    cur_setup = s;
    cur_bits  = b;
  endtask

  // comparator driver: setup pattern, decision bit in last diode cycle, noise elsewhere
  initial begin : driver
    int sj, dcnt;
    sj = 0; dcnt = 0;
    forever begin
      @(negedge clk);
      cmp = 1'($urandom);
      if (preChrg) bi = 0;
      if (setupBias && !preChrg) begin
        cmp = (sj < 64) ? cur_setup[sj] : 1'b1;
        sj++;
      end else sj = 0;
      if (PII1) begin
        dcnt++;
        if (dcnt == DC && bi < N) cmp = cur_bits[bi];
      end else begin
        if (dcnt != 0) bi++;
        dcnt = 0;
      end
    end
  end

  // monitor: per-window event counts, compared against the scoreboard on each valid
  initial begin : monitor
    int src, snk_n, tog, bad, hh, ll;
    logic p1_prev;
    exp_t e;
    src = 0; snk_n = 0; tog = 0; bad = 0; hh = 0; ll = 0; p1_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        src = 0; snk_n = 0; tog = 0; bad = 0; hh = 0; ll = 0;
      end else begin
        if (busy) begin
          if (!src_n) src++;
          if (snk) snk_n++;
          if (cmp_p1 != p1_prev) tog++;
          if (cmp_p1 == cmp_p2) bad++;
          if (PA && PB && !PC && !PD) hh++;
          if (PA && PC && !PB && !PD) ll++;
        end
        if (valid) begin
          if (sb.size() == 0) chk("unexpected_valid", int'(valid), 0);
          else begin
            e = sb.pop_front();
            chk("result", int'(result), e.res);
            chk("setupFail", int'(setupFail), e.fail);
            chk("valid_cycle", cyc, e.vcyc);
            chk("src_n_pulses", src, e.src);
            chk("snk_pulses", snk_n, e.snk);
            chk("cmp_p_toggles", tog, N + 1);
            chk("cmp_p_not_compl", bad, 0);
            chk("charge_h_cycles", hh, e.ones * CH);
            chk("charge_l_cycles", ll, (N - e.ones) * CH);
          end
          src = 0; snk_n = 0; tog = 0; bad = 0; hh = 0; ll = 0;
        end
      end
      p1_prev = cmp_p1;
    end
  end

  task automatic wait_valid(input bit noise);
    bit got;
    int n;
    got = 0; n = 0;
    while (!got && n < 4000) begin
      @(negedge clk);
      n++;
      if (valid) got = 1;
      start = (noise && !got) ? ($urandom_range(0, 31) == 0) : 1'b0;
    end
    start = 1'b0;
    chk("valid_seen", int'(got), 1);
  endtask

  task automatic run_single(input int sm, input int bm, input bit noise);
    exp_t e;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    prep(sm, bm, cyc + 1, 1'b0, e);
    sb.push_back(e);
    start = 1'b1;
    wait_valid(noise);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    exp_t e;
    int v, n;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(outvec()), int'(RST_VEC));
    chk("reset_result", int'(result), 0);
    reset = 1'b0;
    @(negedge clk);

    run_single(1, 1, 1'b0);  // all-high decisions -> full scale
    run_single(1, 2, 1'b0);  // all-low decisions, 5-cycle setup
    run_single(0, 3, 1'b0);  // alternating decisions
    run_single(2, 0, 1'b1);  // setup timeout, start noise while busy
    run_single(3, 0, 1'b0);  // fifth low lands on the timeout cycle
    run_single(0, 0, 1'b1);  // random, setupFail cleared by new start

    // abort by reset in the diode phase of iteration 7
    repeat (2) @(negedge clk);
    prep(0, 0, cyc + 1, 1'b0, e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(bi == 6 && PII1) && n < 2000) begin @(negedge clk); n++; end
    chk("reached_iter7_diode", int'(bi == 6 && PII1), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midconv_reset_outputs", int'(outvec()), int'(RST_VEC));
    chk("midconv_reset_result", int'(result), 0);
    reset = 1'b0;
    v = 0;
    repeat (20) begin @(negedge clk); if (valid) v++; end
    chk("no_valid_after_reset", v, 0);
    chk("idle_after_reset", int'(busy), 0);

    // continuous chain of three conversions; setupFail sticky across the chain
    continuous = 1'b1;
    prep(0, 0, cyc + 1, 1'b0, e);
    sb.push_back(e);
    v = e.vcyc;
    start = 1'b1;
    wait_valid(1'b1);
    prep(2, 0, v + 1, 1'b1, e);
    sb.push_back(e);
    v = e.vcyc;
    wait_valid(1'b1);
    prep(0, 3, v + 1, 1'b1, e);
    sb.push_back(e);
    @(negedge clk);
    continuous = 1'b0;
    wait_valid(1'b1);

    repeat (3) @(negedge clk);
    chk("idle_at_end", int'(busy), 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
